multicycle_cpu: RTL

- Parametrised multi-cycle successor to the single-cycle 9-bit-ISA core.
- Data width, PC width and retire-counter width are parameters.
- Instruction and data memories are external, behind req/ack handshakes, so the core tolerates wait states.
- A control FSM sequences FETCH/EXEC/MEM/HALT in place of the single-cycle datapath.

---
 rtl/multicycle_cpu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: parametrised multi-cycle 9-bit-ISA core with handshaked instruction and data memories
module multicycle_cpu #(
    parameter int DW = 8,
    parameter int PW = 8,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          init,
    output logic          imem_req,
    output logic [PW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [8:0]    imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [PW-1:0] pc,
    output logic          halted,
    output logic [CW-1:0] retired
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d, pc_inc, br_tgt;
    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic          z_q, z_d, c_q, c_d;
    logic [8:0]    ir_q, ir_d;
    logic [CW-1:0] ret_q, ret_d, ret_inc;
    logic [2:0]    op, rd, rs;
    logic [DW-1:0] a, b, alu;
    logic [DW:0]   sum, dif;

    assign op      = ir_q[8:6];
    assign rd      = ir_q[5:3];
    assign rs      = ir_q[2:0];
    assign a       = rf_q[rd];
    assign b       = rf_q[rs];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign dif     = {1'b0, a} - {1'b0, b};
    assign alu     = op == 3'd0 ? sum[DW-1:0] :
                     op == 3'd1 ? dif[DW-1:0] :
                     op == 3'd2 ? a & b :
                     op == 3'd3 ? a ^ b : DW'(ir_q[2:0]);
    assign pc_inc  = pc_q + PW'(1);
    // Branch targets come from a register; truncated or zero-extended to the PC width
    assign br_tgt  = PW'(b);
    assign ret_inc = &ret_q ? ret_q : ret_q + CW'(1);

    // Requests are suppressed while init is held so the reset cycle never shows a handshake
    assign imem_req   = state_q == S_FETCH && !init;
    assign imem_addr  = pc_q;
    assign dmem_req   = state_q == S_MEM && !init;
    assign dmem_we    = dmem_req && op == 3'd6;
    assign dmem_addr  = b;
    assign dmem_wdata = a;
    assign pc         = pc_q;
    assign halted     = state_q == S_HALT;
    assign retired    = ret_q;

    // Control FSM and architectural next-state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rf_d    = rf_q;
        z_d     = z_q;
        c_d     = c_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                ret_d   = ret_inc;
                if (op == 3'd5 || op == 3'd6) begin
                    state_d = S_MEM;
                    pc_d    = pc_q;
                    ret_d   = ret_q;
                end else if (op == 3'd7) begin
                    if (rd == 3'd7) begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end else if ((rd == 3'd0 && z_q) || rd == 3'd1) begin
                        pc_d = br_tgt;
                    end
                end else begin
                    rf_d[rd] = alu;
                    z_d      = op == 3'd4 ? z_q : alu == '0;
                    c_d      = op == 3'd0 ? sum[DW] : op == 3'd1 ? dif[DW] : c_q;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == 3'd5) rf_d[rd] = dmem_rdata;
                    pc_d    = pc_inc;
                    ret_d   = ret_inc;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    // State registers; init overrides any in-flight handshake
    always_ff @(posedge CLK) begin
        if (init) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            rf_q    <= '{default: '0};
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ir_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rf_q    <= rf_d;
            z_q     <= z_d;
            c_q     <= c_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
        end
    end
endmodule
